aes_key_sched: RTL and testbench
================================

Name: aes_key_sched

Overview:
- Iterative AES-128 key-expansion unit that sits directly upstream of the vector AES datapath.
- Takes a 128-bit cipher key and generates the 11 round keys (rk0..rk10), one round key per clock.
- Stores the round keys in an internal buffer and presents any one of them on a read port. The datapath consumes that port as its vb/a round-key operand for AddRoundKey.
- Byte/word ordering matches the datapath:
  - word j at [32j+31:32j];
  - byte i of the key/state at [8i+7:8i];
  - RotWord of w3 = {w3[7:0], w3[31:8]};
  - Rcon is XORed into byte 0, bits [7:0].

Parameters:
- NR, 10, number of rounds; the buffer holds NR+1 round keys; only 10 (AES-128) is supported.
- IDXW, 4, width of the round-key read index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  synchronous active-low reset.
- start  in  1  request a new expansion; sampled only in IDLE.
- key_in  in  128  cipher key; sampled on the accepted start edge.
- busy  out  1  high while an expansion is in progress.
- done  out  1  one-cycle pulse after rk10 is written.
- keys_valid  out  1  high when the buffer holds a complete schedule.
- rk_idx  in  IDXW  round-key read index.
- rk_data  out  128  round key rk[rk_idx]; combinational read.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low (clrn): it acts only on a rising clk edge where clrn=0.
- Reset values:
  - state=IDLE; busy=0, done=0, keys_valid=0;
  - round counter=0, rcon=8'h01;
  - all 11 buffer entries=0.
- Reset wins over every other input at the same edge, including mid-expansion. A partial schedule is discarded and keys_valid stays 0.
- FSM states: IDLE, EXPAND, FIN.
- IDLE & start=1:
  - rk[0]<=key_in, rcon<=8'h01, round<=1;
  - keys_valid<=0, busy<=1, state<=EXPAND.
- EXPAND, each edge:
  - rk[round]<=f(rk[round-1], rcon), rcon<=xt2(rcon), round<=round+1;
  - when round==NR, go to FIN instead.
- FIN, one cycle:
  - done<=1, busy<=0, keys_valid<=1, state<=IDLE;
  - done clears on the following edge.
- Timing: start accepted at edge E. rk1..rk10 are written at edges E+1..E+10. done and keys_valid are high after edge E+11, so done is high during the cycle following E+11. busy is high from E through E+10.
- f(w, rcon), with w0..w3 the words of the previous key:
  - t = SubWord(RotWord(w3)) ^ {24'h0, rcon};
  - n0 = w0 ^ t;
  - n1 = w1 ^ n0;
  - n2 = w2 ^ n1;
  - n3 = w3 ^ n2.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36. xt2(x) = (x<<1) ^ (x[7] ? 8'h1b : 0), truncated to 8 bits.
- SubWord uses 4 forward S-box lookups in parallel; the next-key logic is combinational.
- start while busy or in FIN: ignored, with no queuing. key_in changes after the accepted edge have no effect.
- start held high continuously: a new expansion begins on the first IDLE edge after FIN.
- rk_idx > NR: rk_data = 128'h0.
- Reading an entry not yet written in the current run returns its old contents. keys_valid tells the consumer whether the schedule is complete.

Decomposition:
- Shared package aes_pkg holds:
  - constants AES_NR=10, RCON_INIT=8'h01, GF_POLY=8'h1b;
  - the state encoding;
  - function xt2.
- Natural sub-module: aes_sbox, an 8-bit forward S-box, combinational, 4 instances. It is reusable by the datapath's SubBytes path.

Test Plan:
- FIPS-197 key, key_in=128'h3c4fcf098815f7aba6d2ae2816157e2b, start pulse:
  - done pulses exactly 11 cycles after the start edge;
  - rk_idx=1 -> 128'h05766c2a3939a323b12c548817fefaa0;
  - rk_idx=10 -> 128'ha60c63b6c80c3fe18925eec9a8f914d0;
  - rk_idx=0 -> key_in.
- All-zero key:
  - rk1=128'h63636362636363626363636263636362;
  - rk10=128'h8e188f6fcf51e92311e2923ecb5befb4;
  - keys_valid=1 after done.
- Second start with a different key during EXPAND (cycle 5): ignored; the schedule matches the first key, with exactly one done pulse.
- clrn=0 at cycle 6 of an expansion: next cycle busy=0, keys_valid=0, all rk reads=0. A fresh start then yields the correct FIPS schedule.
- rk_idx=11..15 -> rk_data=0. With start held high for 30 cycles, done pulses at cycles 11 and 23, with busy low only in each FIN cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, Rcon seed, field polynomial,
// key-schedule FSM encoding and the GF(2^8) doubling helper.
package aes_pkg;

  localparam int         AES_NR    = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] GF_POLY   = 8'h1b;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    FIN    = 2'd2
  } ks_state_t;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xt2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Purely combinational; shared with the SubBytes path.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] t;
    acc = 8'h00;
    t   = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ t;
      t = xt2(t);
    end
    return acc;
  endfunction

  // x^254 == x^-1 for nonzero x, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  assign inv = gf_inv(a);
  assign s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion: one round key per clock into an
// 11-entry buffer, read back combinationally by index.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int NR   = AES_NR,
  parameter int IDXW = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [127:0]     key_in,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [IDXW-1:0]  rk_idx,
  output logic [127:0]     rk_data
);

  ks_state_t       state;
  logic [IDXW-1:0] round;
  logic [7:0]      rcon;
  logic [127:0]    rk_buf [NR+1];

  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  t_word;
  logic [31:0]  n0, n1, n2, n3;

  assign prev_key = rk_buf[round - IDXW'(1)];
  assign rot_w3   = {prev_key[103:96], prev_key[127:104]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (
      .a (rot_w3[8*g +: 8]),
      .s (sub_w3[8*g +: 8])
    );
  end

  assign t_word   = sub_w3 ^ {24'h0, rcon};
  assign n0       = prev_key[31:0]   ^ t_word;
  assign n1       = prev_key[63:32]  ^ n0;
  assign n2       = prev_key[95:64]  ^ n1;
  assign n3       = prev_key[127:96] ^ n2;
  assign next_key = {n3, n2, n1, n0};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      round      <= '0;
      rcon       <= RCON_INIT;
      // NOTE: the key buffer is deliberately reset so a consumer reading
      // before any expansion sees zeros instead of stale or unknown keys.
      for (int i = 0; i <= NR; i++) rk_buf[i] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rk_buf[0]  <= key_in;
            rcon       <= RCON_INIT;
            round      <= IDXW'(1);
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          rk_buf[round] <= next_key;
          rcon          <= xt2(rcon);
          if (round == IDXW'(NR)) state <= FIN;
          else                    round <= round + IDXW'(1);
        end
        FIN: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          keys_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: a default assignment ahead of the branch keeps this combinational
  // read from inferring a latch.
  always_comb begin
    rk_data = '0;
    if (rk_idx <= IDXW'(NR)) rk_data = rk_buf[rk_idx];
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Scoreboard bench for aes_key_sched: stimulus queues reference schedules,
// a monitor compares all round keys whenever done pulses.
`timescale 1ns/1ps
module tb_aes_key_sched;

  localparam int NR   = 10;
  localparam int IDXW = 4;

  typedef logic [NR:0][127:0] sched_t;
  typedef struct packed {
    sched_t rk;
    int     accept;
  } exp_t;

  localparam logic [127:0] FIPS_KEY  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] FIPS_RK1  = 128'h05766c2a3939a323b12c548817fefaa0;
  localparam logic [127:0] FIPS_RK10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
  localparam logic [127:0] ZERO_RK1  = 128'h63636362636363626363636263636362;
  localparam logic [127:0] ZERO_RK10 = 128'h8e188f6fcf51e92311e2923ecb5befb4;

  logic            clk = 1'b0;
  logic            clrn = 1'b0;
  logic            start = 1'b0;
  logic [127:0]    key_in = '0;
  logic            busy, done, keys_valid;
  logic [IDXW-1:0] rk_idx;
  logic [IDXW-1:0] stim_idx = '0;
  logic [IDXW-1:0] mon_idx = '0;
  logic            mon_active = 1'b0;
  logic [127:0]    rk_data;

  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  exp_t sb[$];

  logic [7:0] sbox_tab [256];
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  assign rk_idx = mon_active ? mon_idx : stim_idx;

  aes_key_sched #(.NR(NR), .IDXW(IDXW)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_idx     (rk_idx),
    .rk_data    (rk_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box table from the generator-3 walk of GF(2^8) plus the affine map.
  function automatic void build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tab[p] = x ^ 8'h63;
    end
    sbox_tab[0] = 8'h63;
  endfunction

  // Textbook word-array key expansion with the block's byte ordering.
  function automatic sched_t expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    sched_t      s;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {24'h0, rcon_tab[i/4 - 1]};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) s[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    return s;
  endfunction

  function automatic exp_t make_exp(input logic [127:0] key, input int accept);
    exp_t e;
    e.rk     = expand(key);
    e.accept = accept;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest pending schedule.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 at edge %0d, expected no pending schedule", edge_cnt);
        end else begin
          e = sb.pop_front();
          check("done_latency", 128'(edge_cnt - e.accept), 128'd11);
          check("keys_valid_at_done", 128'(keys_valid), 128'd1);
          check("busy_at_done", 128'(busy), 128'd0);
          mon_active = 1'b1;
          for (int i = 0; i < 16; i++) begin
            mon_idx = IDXW'(i);
            #0.2;
            if (i <= NR) check($sformatf("rk[%0d]", i), rk_data, e.rk[i]);
            else         check($sformatf("rk[%0d]_oob", i), rk_data, 128'h0);
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  // Pulse start for one cycle from a negedge; key_in is scrambled afterwards.
  task automatic issue(input logic [127:0] k);
    @(negedge clk);
    start  = 1'b1;
    key_in = k;
    sb.push_back(make_exp(k, edge_cnt + 1));
    @(negedge clk);
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d pending schedules after %0d cycles, expected 0", sb.size(), budget);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic read_rk(input string name, input int idx, input logic [127:0] exp);
    stim_idx = IDXW'(idx);
    #0.2;
    check(name, rk_data, exp);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    logic [127:0] k1, k2;
    build_sbox();

    repeat (3) @(negedge clk);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    check("reset_keys_valid", 128'(keys_valid), 128'd0);
    for (int i = 0; i <= NR; i += 5) read_rk($sformatf("reset_rk[%0d]", i), i, 128'h0);
    clrn = 1'b1;

    issue(FIPS_KEY);
    wait_idle(40);
    read_rk("fips_rk0", 0, FIPS_KEY);
    read_rk("fips_rk1", 1, FIPS_RK1);
    read_rk("fips_rk10", 10, FIPS_RK10);

    issue(128'h0);
    wait_idle(40);
    read_rk("zero_rk1", 1, ZERO_RK1);
    read_rk("zero_rk10", 10, ZERO_RK10);
    check("zero_keys_valid", 128'(keys_valid), 128'd1);

    for (int n = 0; n < 6; n++) begin
      issue({$urandom, $urandom, $urandom, $urandom});
      wait_idle(40);
    end

    // Second start during EXPAND must be ignored.
    issue({$urandom, $urandom, $urandom, $urandom});
    repeat (3) @(negedge clk);
    start  = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start  = 1'b0;
    check("busy_mid_expand", 128'(busy), 128'd1);
    wait_idle(40);
    repeat (15) @(negedge clk);

    // Reset at cycle 6 of an expansion discards the partial schedule.
    issue({$urandom, $urandom, $urandom, $urandom});
    repeat (4) @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    void'(sb.pop_back());
    check("midreset_busy", 128'(busy), 128'd0);
    check("midreset_keys_valid", 128'(keys_valid), 128'd0);
    check("midreset_done", 128'(done), 128'd0);
    for (int i = 0; i <= NR; i++) read_rk($sformatf("midreset_rk[%0d]", i), i, 128'h0);
    clrn = 1'b1;
    issue(FIPS_KEY);
    wait_idle(40);
    read_rk("refips_rk1", 1, FIPS_RK1);
    read_rk("refips_rk10", 10, FIPS_RK10);
    for (int i = NR + 1; i < 16; i++) read_rk($sformatf("oob_rk[%0d]", i), i, 128'h0);

    // start held for 30 cycles: back-to-back expansions 12 edges apart.
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start  = 1'b1;
    key_in = k1;
    sb.push_back(make_exp(k1, edge_cnt + 1));
    sb.push_back(make_exp(k1, edge_cnt + 13));
    sb.push_back(make_exp(k2, edge_cnt + 25));
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check($sformatf("held_busy[%0d]", k), 128'(busy), (k == 11 || k == 23) ? 128'd0 : 128'd1);
      if (k == 15) key_in = k2;
    end
    start = 1'b0;
    wait_idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
